// File: rtl/edge_counter_pkg.sv
// Shared types and width constants for the edge counter subsystem.
package edge_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned STROBE_WIDTH     = 1;
    localparam int unsigned EDGE_COUNT_WIDTH = 16;

endpackage

// File: rtl/window_timer.sv
// Cycle index within a measurement window; flags the final cycle of each window.
module window_timer #(
    parameter int unsigned WINDOW_CYCLES = 1000
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic clear,
    input  logic run,
    output logic last
);

    localparam int unsigned WIN_WIDTH = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_WIDTH-1:0] LAST_INDEX = WIN_WIDTH'(WINDOW_CYCLES - 1);

    logic [WIN_WIDTH-1:0] index;

    always_ff @(posedge in_clock) begin
        if (in_reset || clear) begin
            index <= '0;
        end else if (run) begin
            index <= (index == LAST_INDEX) ? '0 : index + 1'b1;
        end
    end

    always_comb begin
        last = (index == LAST_INDEX);
    end

endmodule

// File: rtl/edge_window_counter.sv
// Counts edge strobes over fixed windows and publishes each window's count
// through a valid/ready handshake with saturation and sticky overrun flags.
module edge_window_counter
    import edge_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = EDGE_COUNT_WIDTH,
    parameter int unsigned WINDOW_CYCLES = 1000
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic                   in_enable,
    input  logic                   in_strobe,
    input  logic                   in_ready,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_valid,
    output logic                   out_saturated,
    output logic                   out_overrun,
    output logic                   out_busy
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] acc;
    logic                   acc_sat;
    logic [COUNT_WIDTH-1:0] final_count;
    logic                   final_sat;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   sat_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic                   last;
    logic                   win_end;
    logic                   transfer;
    logic                   timer_clear;
    logic                   timer_run;

    window_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_window_timer (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .clear    (timer_clear),
        .run      (timer_run),
        .last     (last)
    );

    always_comb begin
        win_end     = (state == RUN) && last;
        transfer    = valid_q && in_ready;
        timer_clear = (state == IDLE) || !in_enable;
        timer_run   = (state == RUN);
    end

    // The strobe in the window-end cycle is folded into the published count.
    always_comb begin
        final_count = acc;
        final_sat   = acc_sat;
        if (in_strobe) begin
            if (acc == COUNT_MAX) begin
                final_sat = 1'b1;
            end else begin
                final_count = acc + 1'b1;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_enable)  state_next = RUN;
            RUN:  if (!in_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_busy = (state == RUN);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset || (state == IDLE) || !in_enable || win_end) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else begin
            acc     <= final_count;
            acc_sat <= final_sat;
        end
    end

    // A window end takes priority over a transfer, so a simultaneous accept
    // simply hands over to the new result without flagging overrun.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            count_q   <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (win_end) begin
            count_q <= final_count;
            sat_q   <= final_sat;
            valid_q <= 1'b1;
            if (valid_q && !in_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (transfer) begin
            valid_q <= 1'b0;
        end
    end

    always_comb begin
        out_count     = count_q;
        out_valid     = valid_q;
        out_saturated = sat_q;
        out_overrun   = overrun_q;
    end

endmodule

// File: doc/edge_window_counter.md
Name: edge_window_counter

Overview:
- Downstream consumer of the single-cycle rising-edge strobe produced by the edge detection stage.
- Counts strobes over fixed windows of WINDOW_CYCLES clock cycles.
- At each window end, publishes the count through a valid/ready handshake.
- Flags saturation and unconsumed-result overrun; provides the event-rate measurement for the edge counter subsystem.

Parameters:
- COUNT_WIDTH, 16, width of accumulator and published count; legal range ≥1.
- WINDOW_CYCLES, 1000, window length in clock cycles; legal range ≥2.
- WIN_WIDTH, $clog2(WINDOW_CYCLES), localparam; window index width.

Ports:
- in_clock  input  1  sole clock; all logic on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_enable  input  1  level; high = measure, low = idle.
- in_strobe  input  1  one-cycle edge pulse from upstream; any high cycle counts as one event.
- in_ready  input  1  consumer accepts result this cycle.
- out_count  output  COUNT_WIDTH  published window count.
- out_valid  output  1  out_count/out_saturated valid.
- out_saturated  output  1  published count clipped at max.
- out_overrun  output  1  sticky; a result was overwritten before consumption.
- out_busy  output  1  high while in RUN state.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator 0; window index 0. Reset overrides every other input in the same cycle, including mid-window and pending-result cases; any pending result is lost.
- FSM states: IDLE, RUN.
- IDLE to RUN: in_enable sampled high. Accumulator and window index cleared. in_strobe in that transition cycle is ignored.
- RUN to IDLE: in_enable sampled low. The partial window is discarded; accumulator and index are cleared. A pending out_valid result is retained and remains subject to the handshake.
- RUN counting:
  - Each cycle, if in_strobe=1, accumulator increments by 1.
  - The accumulator saturates at 2^COUNT_WIDTH-1 and sets an internal sat flag; it does not wrap.
  - Window index counts 0..WINDOW_CYCLES-1 and then wraps to 0.
- Window end (RUN with index = WINDOW_CYCLES-1):
  - The strobe in this cycle is included.
  - Next cycle: out_count = final saturated count, out_saturated = sat flag, out_valid = 1.
  - Accumulator and sat flag clear; the next window starts immediately with no gap cycle.
  - Latency: the result is visible one cycle after the last window cycle.
- Handshake:
  - A transfer occurs in any cycle where out_valid=1 and in_ready=1.
  - out_count/out_saturated are held stable while out_valid=1 and no transfer has occurred.
  - After a transfer, out_valid falls the next cycle unless a new window end occurs in the same cycle.
  - Transfer and window end in the same cycle: out_valid stays 1 and the new result loads. This is not an overrun.
- Overrun:
  - Condition: window end while out_valid=1 and in_ready=0.
  - The new result overwrites the old one and out_overrun is set.
  - out_overrun clears only on in_reset.
- out_busy = (state == RUN), registered.
- Disable on the exact window-end cycle: the result is still published; the FSM goes to IDLE.
- Unsigned arithmetic only.

Decomposition:
- Package edge_counter_pkg holds:
  - state typedef (IDLE, RUN);
  - shared strobe/count width constants used by the edge counter subsystem.
- One sub-module, window_timer:
  - parameter WINDOW_CYCLES;
  - inputs in_clock, in_reset, clear, run;
  - output last (high on index WINDOW_CYCLES-1).
- Accumulator, FSM and output register stay in edge_window_counter.

Test Plan (COUNT_WIDTH=4, WINDOW_CYCLES=8 unless stated):
1. in_enable high at edge 0, in_strobe high every RUN cycle, in_ready=1 -> out_valid rises after edge 9; out_count=8, out_saturated=0; out_valid high exactly 1 cycle per window; windows repeat every 8 cycles.
2. Strobe only on the last cycle of the window, then only on the first cycle of the next -> two results, each out_count=1; confirms boundary inclusion and no gap cycle.
3. COUNT_WIDTH=4, WINDOW_CYCLES=20, strobe every cycle -> out_count=15, out_saturated=1; next window with 3 strobes -> out_count=3, out_saturated=0.
4. in_ready=0 across two window ends (counts 5 then 2) -> out_count=2, out_valid=1, out_overrun=1; in_ready=1 -> out_valid=0 next cycle; out_overrun stays 1.
5. 3 strobes, then in_enable low mid-window -> no result, out_busy=0. Re-enable with 1 strobe in a full window -> out_count=1, so the partial window was discarded.
6. in_reset asserted mid-window with out_valid=1 and out_overrun=1 -> next cycle all outputs 0, state IDLE; with enable held high, the first result appears after edge 10 (reset cycle + IDLE→RUN transition cycle + 8 window cycles).
